// File: rtl/qam_tx_sequencer_if.sv
// qam_tx_sequencer_if: serial-bit handshake and symbol/LUT strobe bundle of the QAM TX sequencer
// bit_in/bit_valid/bit_ready: valid/ready serial data stream into the sequencer
// lut_en: sample-advance strobe; sym_sin/sym_cos/sym_strobe: symbol signs and load pulse to the mixer
// master: data source and symbol consumer side; slave: the sequencer
interface qam_tx_sequencer_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic lut_en;
  logic sym_sin;
  logic sym_cos;
  logic sym_strobe;
  modport master (output bit_in, bit_valid, input bit_ready, lut_en, sym_sin, sym_cos, sym_strobe);
  modport slave (input bit_in, bit_valid, output bit_ready, lut_en, sym_sin, sym_cos, sym_strobe);
endinterface

// File: rtl/qam_tx_sequencer.sv
// qam_tx_sequencer: symbol-rate controller packing serial bits into 2-bit QAM symbols on carrier-period boundaries
// clk, rst (async, active-high); start: transmit level; fpp/fmm: divider -1/+1 pulses
// bus (slave): bit stream handshake in, lut_en and sym_sin/sym_cos/sym_strobe out
// underrun: sticky missing-symbol flag; busy: not idle; div_out: current sample divider
// Optional build macro QAM_SEQ_GRAY_EN selects Gray symbol mapping (sym_cos = first ^ second bit)
module qam_tx_sequencer #(
  parameter int DIV_W = 16,
  parameter int DIV_DEFAULT = 50,
  parameter int DIV_MIN = 4,
  parameter int DIV_MAX = 1000,
  parameter int SPS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic fpp,
  input  logic fmm,
  qam_tx_sequencer_if.slave bus,
  output logic underrun,
  output logic busy,
  output logic [DIV_W-1:0] div_out
);
  localparam int SW = $clog2(SPS);
  localparam logic [DIV_W-1:0] DMIN = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DMAX = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] DDEF = DIV_W'(DIV_DEFAULT);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, div_cnt_q, div_cnt_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [1:0] sh_q, sh_d, sh_cnt_q, sh_cnt_d, sh_n, cnt_n;
  logic sym_sin_q, sym_sin_d, sym_cos_q, sym_cos_d, stb_q, stb_d, und_q, und_d;
  logic rdy, acc, running, lut, bnd, full, stop, ld, cos_n;
  always_comb begin
    rdy = state_q != IDLE && sh_cnt_q != 2'd2;
    acc = bus.bit_valid && rdy;
    running = state_q == RUN || state_q == DRAIN;
    // >= so a divider trimmed below the running count still fires at once
    lut = running && div_cnt_q >= div_q - DIV_W'(1);
    bnd = lut && samp_cnt_q == SW'(SPS - 1);
    // shadow as it stands after this cycle's transfer; sh_n[0] is the first bit of the pair
    sh_n = {acc && sh_cnt_q == 2'd1 ? bus.bit_in : sh_q[1], acc && sh_cnt_q == 2'd0 ? bus.bit_in : sh_q[0]};
    cnt_n = sh_cnt_q + {1'b0, acc};
    full = cnt_n == 2'd2;
`ifdef QAM_SEQ_GRAY_EN
    cos_n = sh_n[0] ^ sh_n[1];
`else
    cos_n = sh_n[1];
`endif
    case (state_q)
      IDLE:    state_d = start ? PRIME : IDLE;
      PRIME:   state_d = !start ? IDLE : full ? RUN : PRIME;
      RUN:     state_d = start ? RUN : DRAIN;
      default: state_d = start ? RUN : bnd ? IDLE : DRAIN;
    endcase
    stop = state_d == IDLE;
    // PRIME loads on its second bit; RUN/DRAIN only on a boundary that is not the final one
    ld = full && !stop && (state_q == PRIME || bnd);
    sym_sin_d = ld ? sh_n[0] : sym_sin_q;
    sym_cos_d = ld ? cos_n : sym_cos_q;
    stb_d = ld;
    und_d = und_q || (bnd && !full && !stop);
    sh_d = sh_n;
    sh_cnt_d = ld || stop ? 2'd0 : cnt_n;
    div_cnt_d = running && !lut ? div_cnt_q + DIV_W'(1) : '0;
    samp_cnt_d = !running ? '0 : lut ? samp_cnt_q + SW'(1) : samp_cnt_q;
    div_d = fpp && !fmm ? (div_q > DMIN ? div_q - DIV_W'(1) : DMIN) :
            fmm && !fpp ? (div_q < DMAX ? div_q + DIV_W'(1) : DMAX) : div_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= DDEF;
      div_cnt_q <= '0;
      samp_cnt_q <= '0;
      sh_q <= '0;
      sh_cnt_q <= '0;
      sym_sin_q <= 1'b0;
      sym_cos_q <= 1'b0;
      stb_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      div_cnt_q <= div_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      sh_q <= sh_d;
      sh_cnt_q <= sh_cnt_d;
      sym_sin_q <= sym_sin_d;
      sym_cos_q <= sym_cos_d;
      stb_q <= stb_d;
      und_q <= und_d;
    end
  end
  assign bus.bit_ready = rdy;
  assign bus.lut_en = lut;
  assign bus.sym_sin = sym_sin_q;
  assign bus.sym_cos = sym_cos_q;
  assign bus.sym_strobe = stb_q;
  assign underrun = und_q;
  assign busy = state_q != IDLE;
  assign div_out = div_q;
endmodule

// File: tb/tb_qam_tx_sequencer.sv
// tb_qam_tx_sequencer: directed table-driven and sequence checks of qam_tx_sequencer
`timescale 1ns/1ps
module tb_qam_tx_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic fpp = 1'b0;
  logic fmm = 1'b0;
  logic underrun, busy;
  logic [15:0] div_out;
  logic [15:0] pat;
  int bidx = 0;
  int n_vec = 0;
  int n_bad = 0;
  qam_tx_sequencer_if bus();
  qam_tx_sequencer #(.DIV_W(16), .DIV_DEFAULT(4), .DIV_MIN(2), .DIV_MAX(6), .SPS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .fpp(fpp), .fmm(fmm), .bus(bus),
    .underrun(underrun), .busy(busy), .div_out(div_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st, fp, fm, lut, stb, s0, s1, rdy, bsy, und;
    logic [15:0] div;
  } vec_t;
  vec_t tbl[$];
  function automatic logic gc(logic b0, logic b1);
`ifdef QAM_SEQ_GRAY_EN
    return b0 ^ b1;
`else
    return b1;
`endif
  endfunction
  function automatic logic [22:0] outs();
    return {bus.lut_en, bus.sym_strobe, bus.sym_sin, bus.sym_cos, bus.bit_ready, busy, underrun, div_out};
  endfunction
  function automatic logic [22:0] expw(logic lut, logic stb, logic s0, logic s1, logic rdy, logic bsy, logic und, logic [15:0] div);
    return {lut, stb, s0, gc(s0, s1), rdy, bsy, und, div};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input int n, input logic st, input logic fp, input logic fm, input logic lut, input logic stb,
                     input logic s0, input logic s1, input logic rdy);
    vec_t v;
    v.st = st; v.fp = fp; v.fm = fm; v.lut = lut; v.stb = stb; v.s0 = s0; v.s1 = s1;
    v.rdy = rdy; v.bsy = 1'b1; v.und = 1'b0; v.div = 16'd4;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask
  task automatic cyc();
    logic acc;
    @(negedge clk);
    acc = bus.bit_valid && bus.bit_ready;
    @(posedge clk);
    #1;
    if (acc) bidx++;
    bus.bit_in = pat[15 - (bidx % 16)];
  endtask
  task automatic do_reset();
    start = 1'b0; fpp = 1'b0; fmm = 1'b0; bus.bit_valid = 1'b1; bidx = 0; bus.bit_in = pat[15];
    #2 rst = 1'b1;
    #1 chk("reset", outs(), expw(0, 0, 0, 0, 0, 0, 0, 16'd4));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
  endtask
  task automatic wait_sig(input bit strobe, input int max, output int n);
    n = 0;
    while (n < max && !(strobe ? bus.sym_strobe : bus.lut_en)) begin
      cyc();
      n++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int n, nl;
    // rows are the outputs after clock edges 1..22 following start
    add(2, 1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      add(1, 1, 0, 0, 1, 0, 1, 0, 0);
      add(3, 1, 0, 0, 0, 0, 1, 0, 0);
    end
    add(1, 1, 0, 0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 0, 1, 0);
    pat = 16'b1001_1100_1101_1001;
    do_reset();
    foreach (tbl[i]) begin
      start = tbl[i].st; fpp = tbl[i].fp; fmm = tbl[i].fm;
      cyc();
      chk($sformatf("vec%0d", i + 1), outs(),
          expw(tbl[i].lut, tbl[i].stb, tbl[i].s0, tbl[i].s1, tbl[i].rdy, tbl[i].bsy, tbl[i].und, tbl[i].div));
    end
    fpp = 1'b0; fmm = 1'b0;
    do_reset();
    start = 1'b1;
    repeat (3) cyc();
    bus.bit_valid = 1'b0;
    repeat (15) cyc();
    chk("und_pre_boundary", outs(), expw(1, 0, 1, 0, 1, 1, 0, 16'd4));
    cyc();
    chk("und_set", outs(), expw(0, 0, 1, 0, 1, 1, 1, 16'd4));
    bus.bit_valid = 1'b1;
    wait_sig(1'b1, 40, n);
    chk("und_resume_timeout", n < 40, 1);
    chk("und_resume", outs(), expw(0, 1, 0, 1, 1, 1, 1, 16'd4));
    do_reset();
    start = 1'b1;
    repeat (3) cyc();
    fpp = 1'b1; cyc(); fpp = 1'b0;
    chk("fpp_1", div_out, 3);
    fpp = 1'b1; cyc(); fpp = 1'b0;
    chk("fpp_2", div_out, 2);
    fpp = 1'b1; cyc(); fpp = 1'b0;
    chk("fpp_min", div_out, 2);
    wait_sig(1'b0, 20, n);
    chk("lut_seen", n < 20, 1);
    cyc();
    wait_sig(1'b0, 20, n);
    chk("lut_spacing", n + 1, 2);
    fpp = 1'b1; fmm = 1'b1; cyc(); fpp = 1'b0; fmm = 1'b0;
    chk("fpp_fmm_hold", div_out, 2);
    repeat (4) begin
      fmm = 1'b1; cyc(); fmm = 1'b0;
    end
    chk("fmm_up", div_out, 6);
    fmm = 1'b1; cyc(); fmm = 1'b0;
    chk("fmm_max", div_out, 6);
    do_reset();
    start = 1'b1;
    repeat (8) cyc();
    start = 1'b0;
    nl = 0;
    repeat (10) begin
      cyc();
      nl += int'(bus.lut_en);
    end
    chk("drain_luts", nl, 3);
    chk("drain_busy", busy, 1);
    cyc();
    chk("drain_end", outs(), expw(0, 0, 1, 0, 0, 0, 0, 16'd4));
    do_reset();
    start = 1'b1;
    repeat (8) cyc();
    start = 1'b0;
    repeat (3) cyc();
    chk("restart_in_drain", busy, 1);
    start = 1'b1;
    repeat (3) cyc();
    chk("restart_lut", bus.lut_en, 1);
    repeat (5) cyc();
    chk("restart_sym", outs(), expw(0, 1, 0, 1, 1, 1, 0, 16'd4));
    do_reset();
    start = 1'b1;
    repeat (3) cyc();
    fpp = 1'b1; cyc(); fpp = 1'b0;
    chk("pre_rst_div", div_out, 3);
    #1 rst = 1'b1;
    #1 chk("async_rst", outs(), expw(0, 0, 0, 0, 0, 0, 0, 16'd4));
    #1 rst = 1'b0;
    cyc();
    chk("prime_ready", bus.bit_ready, 1);
    cyc();
    chk("prime_no_stb", bus.sym_strobe, 0);
    cyc();
    chk("prime_stb", bus.sym_strobe, 1);
    pat = 16'b1101_1010_0110_0011;
    do_reset();
    start = 1'b1;
    repeat (3) cyc();
    chk("map_11", {bus.sym_strobe, bus.sym_sin, bus.sym_cos}, {1'b1, 1'b1, gc(1'b1, 1'b1)});
    repeat (16) cyc();
    chk("map_01", {bus.sym_strobe, bus.sym_sin, bus.sym_cos}, {1'b1, 1'b0, gc(1'b0, 1'b1)});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/qam_tx_sequencer.md
Name: qam_tx_sequencer

Overview:
- Symbol-rate controller for the QAM transmit datapath.
- Pulls serial data bits through a valid/ready handshake and packs them into 2-bit symbols (sine sign, cosine sign) for the mixer.
- Paces the sin/cos LUT with a programmable sample-enable strobe whose period is trimmed at run time by the fpp/fmm frequency buttons.
- Applies each new symbol exactly on a carrier-period boundary, replacing the free-running enable counter and ad-hoc serial-to-parallel timing.

Parameters:
- DIV_W, 16, width of the sample-divider register and counter.
- DIV_DEFAULT, 50, divider value loaded at reset (clk cycles per lut_en).
- DIV_MIN, 4, lower saturation limit of the divider.
- DIV_MAX, 1000, upper saturation limit of the divider.
- SPS, 16, LUT samples per symbol (one carrier period); must be a power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  level; 1 = transmit, 0 = stop at the next symbol boundary
- fpp  in  1  one-cycle pulse; raise carrier frequency (divider -1)
- fmm  in  1  one-cycle pulse; lower carrier frequency (divider +1)
- bit_in  in  1  serial data bit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  sequencer accepts bit_in this cycle
- lut_en  out  1  one-cycle sample-advance strobe to the sin/cos LUT
- sym_sin  out  1  sine-branch sign bit to the mixer
- sym_cos  out  1  cosine-branch sign bit to the mixer
- sym_strobe  out  1  one-cycle pulse; new sym_sin/sym_cos valid this cycle
- underrun  out  1  sticky; a symbol boundary occurred with no complete symbol buffered
- busy  out  1  state is not IDLE
- div_out  out  DIV_W  current divider value

Behaviour:
- Reset values: state IDLE, divider = DIV_DEFAULT, all counters 0, shadow buffer empty; all 1-bit outputs 0; div_out = DIV_DEFAULT.
- Handshake: a bit transfers on a rising edge when bit_valid && bit_ready. bit_ready is 0 in IDLE. In PRIME/RUN/DRAIN it is 1 while the 2-bit shadow buffer is not full.
- Bit order: the first bit of a pair goes to the sine sign, the second to the cosine sign.
- State IDLE: when start = 1, go to PRIME. A partial shadow buffer is cleared on entry to IDLE.
- State PRIME: collect bits.
  - On the edge that accepts the second bit, go to RUN.
  - In the first RUN cycle: sym_* = shadow contents, sym_strobe = 1, shadow empty, div_cnt = 0, samp_cnt = 0.
  - If start falls while in PRIME, return to IDLE.
- State RUN:
  - div_cnt increments every cycle.
  - lut_en = 1 in any cycle where div_cnt >= divider-1; that cycle also resets div_cnt to 0. The >= compare covers a divider that shrinks below the current count.
  - samp_cnt increments on each lut_en and wraps at SPS-1.
  - Symbol boundary = a lut_en cycle with samp_cnt = SPS-1. In the next cycle one of the following happens:
    - Shadow full: load sym_*, pulse sym_strobe, empty the shadow.
    - Shadow not full: hold sym_*, no sym_strobe, set underrun. Any half-collected bit is kept.
  - A bit accepted in the boundary cycle itself counts toward the shadow before the check.
  - Symbol period = SPS × divider cycles.
- State DRAIN: entered from RUN when start = 0 is sampled.
  - Keeps issuing lut_en until the next symbol boundary.
  - At that boundary go to IDLE; no new symbol is loaded.
  - sym_* keep their last values.
  - If start returns to 1 during DRAIN, go back to RUN with no gap.
- Divider update (any state):
  - fpp alone: divider = max(divider-1, DIV_MIN).
  - fmm alone: divider = min(divider+1, DIV_MAX).
  - Both in the same cycle: no change.
  - The new value is used from the next cycle.
- underrun: cleared only by rst.
- busy = (state != IDLE).
- Asynchronous reset at any point: every register returns to its reset value immediately; a partial symbol is discarded.

Optional Feature:
- Macro QAM_SEQ_GRAY_EN.
- Defined: Gray mapping. sym_sin = first bit, sym_cos = first bit XOR second bit, so adjacent constellation points differ by one bit.
- Undefined: natural mapping as described in Behaviour. Timing is identical in both builds.

Test Plan:
- Bench uses DIV_DEFAULT=4, SPS=4, bit_valid held at 1.
- Basic run: rst pulse, start=1, bits 1,0,0,1 → first sym_strobe with sym_sin=1, sym_cos=0; lut_en every 4 cycles; second sym_strobe 16 cycles later with 0,1; underrun=0.
- Underrun: supply 2 bits, then bit_valid=0 → at the first boundary sym_* hold 1,0, no sym_strobe, underrun=1 and stays 1 after bits resume.
- Frequency trim: 3 fpp pulses → div_out = 4→3→…→DIV_MIN (set DIV_MIN=2, final value 2), lut_en spacing 2. A simultaneous fpp+fmm leaves div_out unchanged. fmm at DIV_MAX stays at DIV_MAX.
- Stop/restart: drop start mid-symbol → lut_en continues to the boundary, then busy=0 and bit_ready=0. Re-raise start in DRAIN → RUN continues with no lut_en gap.
- Async reset mid-symbol: assert rst between clock edges → all outputs 0 and div_out=4 immediately. After release, PRIME needs 2 fresh bits before sym_strobe.
- With QAM_SEQ_GRAY_EN: bits 1,1 → sym_sin=1, sym_cos=0. Bits 0,1 → sym_sin=0, sym_cos=1.
